// File: rtl/enum_arbiter_if.sv
// Bundle of the enum_arbiter request/response signals.
// The master side drives per-channel stream parameters and requests;
// the slave side (the arbiter) returns acks, end-of-list flags and data.
interface enum_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       start;
    logic [N*WIDTH-1:0] min_bus;
    logic [N*WIDTH-1:0] step_bus;
    logic [N*WIDTH-1:0] max_bus;
    logic [N-1:0]       req;
    logic [N-1:0]       ack;
    logic [N-1:0]       eol;
    logic [WIDTH-1:0]   value;
    logic [LW-1:0]      grant_id;

    modport master (
        output start, min_bus, step_bus, max_bus, req,
        input  ack, eol, value, grant_id
    );

    modport slave (
        input  start, min_bus, step_bus, max_bus, req,
        output ack, eol, value, grant_id
    );
endinterface

// File: rtl/enum_arbiter.sv
// N-channel arithmetic-sequence enumerator sharing one output bus.
// Each channel walks cur = min, min+step, ... up to max; a round-robin
// arbiter hands out one element per cycle with one cycle of latency.
module enum_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    enum_arbiter_if.slave bus
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRESH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } ch_state_e;

    // Per-channel stream state
    ch_state_e        st_q   [N];
    ch_state_e        st_d   [N];
    logic [WIDTH-1:0] cur_q  [N];
    logic [WIDTH-1:0] cur_d  [N];
    logic [WIDTH-1:0] step_q [N];
    logic [WIDTH-1:0] step_d [N];
    logic [WIDTH-1:0] max_q  [N];
    logic [WIDTH-1:0] max_d  [N];

    // Arbiter and output registers
    logic [LW-1:0]    last_q, last_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [N-1:0]     eol_q, eol_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [LW-1:0]    gid_q, gid_d;

    // Unpacked views of the input buses and per-channel eligibility
    logic [WIDTH-1:0] min_in  [N];
    logic [WIDTH-1:0] step_in [N];
    logic [WIDTH-1:0] max_in  [N];
    logic [N-1:0]     elig;

    logic             grant;
    logic [LW-1:0]    win;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            assign min_in[gi]  = bus.min_bus[gi*WIDTH +: WIDTH];
            assign step_in[gi] = bus.step_bus[gi*WIDTH +: WIDTH];
            assign max_in[gi]  = bus.max_bus[gi*WIDTH +: WIDTH];
            // A start in the same cycle pre-empts any grant to this channel
            assign elig[gi] = bus.req[gi] & ~bus.start[gi] &
                              ((st_q[gi] == FRESH) || (st_q[gi] == RUN));
        end
    endgenerate

    // Round-robin pick: scan downward in offset so the nearest channel
    // after last_q is the final (winning) assignment.
    always_comb begin
        logic [LW-1:0] idx;
        grant = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = last_q + k[LW-1:0];
            if (elig[idx]) begin
                grant = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state per channel: reload on start, advance or finish on grant.
    // The sum is one bit wider so a carry shows up as nxt > max.
    always_comb begin
        logic [WIDTH:0] nxt;
        nxt = '0;
        for (int c = 0; c < N; c++) begin
            st_d[c]   = st_q[c];
            cur_d[c]  = cur_q[c];
            step_d[c] = step_q[c];
            max_d[c]  = max_q[c];
            nxt       = {1'b0, cur_q[c]} + {1'b0, step_q[c]};
            if (bus.start[c]) begin
                cur_d[c]  = min_in[c];
                step_d[c] = step_in[c];
                max_d[c]  = max_in[c];
                st_d[c]   = (min_in[c] > max_in[c]) ? DONE : FRESH;
            end else if (grant && (win == c[LW-1:0])) begin
                if ((step_q[c] == '0) || (nxt > {1'b0, max_q[c]})) begin
                    st_d[c] = DONE;
                end else begin
                    cur_d[c] = nxt[WIDTH-1:0];
                    st_d[c]  = RUN;
                end
            end
        end
    end

    // Output decode: ack/value/grant_id follow the grant one cycle later,
    // eol tracks the channel's upcoming DONE state so it rises with the last ack.
    always_comb begin
        ack_d   = '0;
        value_d = value_q;
        gid_d   = gid_q;
        last_d  = last_q;
        if (grant) begin
            ack_d   = N'(1) << win;
            value_d = cur_q[win];
            gid_d   = win;
            last_d  = win;
        end
        for (int c = 0; c < N; c++) begin
            eol_d[c] = (st_d[c] == DONE);
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < N; c++) begin
                st_q[c]   <= IDLE;
                cur_q[c]  <= '0;
                step_q[c] <= '0;
                max_q[c]  <= '0;
            end
            last_q  <= LW'(N - 1);
            ack_q   <= '0;
            eol_q   <= '0;
            value_q <= '0;
            gid_q   <= '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                st_q[c]   <= st_d[c];
                cur_q[c]  <= cur_d[c];
                step_q[c] <= step_d[c];
                max_q[c]  <= max_d[c];
            end
            last_q  <= last_d;
            ack_q   <= ack_d;
            eol_q   <= eol_d;
            value_q <= value_d;
            gid_q   <= gid_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.eol      = eol_q;
    assign bus.value    = value_q;
    assign bus.grant_id = gid_q;

endmodule

// File: tb/tb_enum_arbiter.sv
// Bench for enum_arbiter: a queue-based model predicts every output each
// cycle, and directed scenarios pin the delivered sequences to literals.
module tb_enum_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    enum_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    enum_arbiter #(.N(N), .WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: each started channel owns the list of elements still to deliver
    int           mq [N][$];
    bit           started [N];
    int           last;
    logic [N-1:0] e_ack;
    logic [N-1:0] e_eol;
    logic [W-1:0] e_val;
    logic [1:0]   e_gid;

    // Delivered (channel, value) pairs as seen on the DUT outputs
    int log_ch[$];
    int log_val[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            mq[c].delete();
            started[c] = 1'b0;
        end
        last  = N - 1;
        e_ack = '0;
        e_eol = '0;
        e_val = '0;
        e_gid = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] el;
        bit found;
        int w;
        found = 1'b0;
        w     = 0;
        for (int c = 0; c < N; c++)
            el[c] = bus.req[c] && !bus.start[c] && (mq[c].size() > 0);
        for (int k = 1; k <= N; k++) begin
            if (!found && el[(last + k) % N]) begin
                found = 1'b1;
                w     = (last + k) % N;
            end
        end
        e_ack = '0;
        if (found) begin
            e_ack[w] = 1'b1;
            e_val    = W'(mq[w].pop_front());
            e_gid    = 2'(w);
            last     = w;
        end
        for (int c = 0; c < N; c++) begin
            if (bus.start[c]) begin
                int mn, st, mx, v;
                mn = int'(bus.min_bus[c*W +: W]);
                st = int'(bus.step_bus[c*W +: W]);
                mx = int'(bus.max_bus[c*W +: W]);
                started[c] = 1'b1;
                mq[c].delete();
                v = mn;
                while (v <= mx) begin
                    mq[c].push_back(v);
                    if (st == 0) break;
                    v = v + st;
                end
            end
        end
        for (int c = 0; c < N; c++)
            e_eol[c] = started[c] && (mq[c].size() == 0);
    endtask

    // Compare process: advance the model on every clock edge or reset
    // assertion, then check all outputs shortly afterwards.
    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
            #1;
            chk("ack",      int'(bus.ack),      int'(e_ack));
            chk("eol",      int'(bus.eol),      int'(e_eol));
            chk("value",    int'(bus.value),    int'(e_val));
            chk("grant_id", int'(bus.grant_id), int'(e_gid));
            if (bus.ack != '0) begin
                $display("ack ch=%0d value=%0d eol=%b t=%0t", bus.grant_id, bus.value, bus.eol, $time);
                log_ch.push_back(int'(bus.grant_id));
                log_val.push_back(int'(bus.value));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_ch(input int c, input int mn, input int st, input int mx);
        bus.min_bus[c*W +: W]  = W'(mn);
        bus.step_bus[c*W +: W] = W'(st);
        bus.max_bus[c*W +: W]  = W'(mx);
    endtask

    // One-cycle start pulse on channel c; returns at the following negedge
    task automatic do_start(input int c, input int mn, input int st, input int mx);
        @(negedge clock);
        set_ch(c, mn, st, mx);
        bus.start[c] = 1'b1;
        @(negedge clock);
        bus.start = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
    endtask

    int  base;
    int  base2;
    bit  found;

    initial begin
        bus.start    = '0;
        bus.req      = '0;
        bus.min_bus  = '0;
        bus.step_bus = '0;
        bus.max_bus  = '0;
        cycles(3);
        reset_n = 1'b1;

        // Simple stream 3,5,7,9 on channel 0
        base = log_val.size();
        do_start(0, 3, 2, 9);
        bus.req[0] = 1'b1;
        cycles(8);
        bus.req = '0;
        cycles(1);
        chk("s1_count", log_val.size() - base, 4);
        if (log_val.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("s1_val", log_val[base+i], 3 + 2*i);
                chk("s1_ch",  log_ch[base+i], 0);
            end
        end
        chk("s1_eol0", int'(bus.eol[0]), 1);

        // Four channels round-robin from a fresh reset
        do_reset();
        base = log_val.size();
        @(negedge clock);
        for (int c = 0; c < N; c++) set_ch(c, 10*c, 1, 10*c + 2);
        bus.start = '1;
        @(negedge clock);
        bus.start = '0;
        bus.req   = '1;
        cycles(16);
        bus.req = '0;
        cycles(1);
        chk("s2_count", log_val.size() - base, 12);
        if (log_val.size() >= base + 12) begin
            for (int i = 0; i < 12; i++) begin
                chk("s2_gid", log_ch[base+i], i % 4);
                chk("s2_val", log_val[base+i], 10*(i % 4) + i / 4);
            end
        end
        chk("s2_eol", int'(bus.eol), 15);

        // Carry case: 250 + 10 overflows 8 bits, must finish after one element
        base = log_val.size();
        do_start(1, 250, 10, 255);
        bus.req[1] = 1'b1;
        cycles(4);
        bus.req = '0;
        cycles(1);
        chk("s3_count", log_val.size() - base, 1);
        if (log_val.size() >= base + 1) chk("s3_val", log_val[base], 250);
        chk("s3_eol1", int'(bus.eol[1]), 1);

        // Empty range: min > max finishes immediately, requests ignored
        base = log_val.size();
        do_start(2, 8, 1, 5);
        chk("s4_eol2_now", int'(bus.eol[2]), 1);
        bus.req[2] = 1'b1;
        cycles(5);
        bus.req = '0;
        cycles(1);
        chk("s4_count", log_val.size() - base, 0);

        // Restart channel 3 mid-stream right after element 4 is delivered
        base = log_val.size();
        do_start(3, 0, 1, 100);
        bus.req[3] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (bus.ack[3] && bus.value == 8'd4) found = 1'b1;
        end
        chk("s5_saw4", int'(found), 1);
        if (found) begin
            set_ch(3, 50, 1, 100);
            bus.start[3] = 1'b1;
            @(negedge clock);
            chk("s5_noack_at_start", int'(bus.ack), 0);
            bus.start = '0;
            cycles(3);
        end
        bus.req = '0;
        cycles(1);
        chk("s5_count", log_val.size() - base, 8);
        if (log_val.size() >= base + 8) begin
            for (int i = 0; i < 5; i++) chk("s5_old_val", log_val[base+i], i);
            for (int i = 0; i < 3; i++) chk("s5_new_val", log_val[base+5+i], 50 + i);
        end

        // Asynchronous reset mid-stream clears outputs at once and aborts streams
        do_start(0, 0, 1, 200);
        bus.req[0] = 1'b1;
        cycles(3);
        #3;
        reset_n = 1'b0;
        #1;
        chk("s6_ack_rst",   int'(bus.ack),      0);
        chk("s6_eol_rst",   int'(bus.eol),      0);
        chk("s6_value_rst", int'(bus.value),    0);
        chk("s6_gid_rst",   int'(bus.grant_id), 0);
        cycles(2);
        reset_n = 1'b1;
        base2 = log_val.size();
        cycles(5);
        bus.req = '0;
        cycles(1);
        chk("s6_no_ack_after", log_val.size() - base2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
